// File: rtl/n64adv_deblur_detect_pkg.sv
// Shared video parameters for the auto-deblur detector:
// colour width, sync bit positions, detector defaults, demux phases.
package n64adv_deblur_detect_pkg;

  localparam int COLOR_W   = 7;
  localparam int VSYNC_BIT = 3;
  localparam int CLAMP_BIT = 2;
  localparam int HSYNC_BIT = 1;
  localparam int CSYNC_BIT = 0;

  localparam int DEBLUR_DIFF_THRESHOLD = 16;
  localparam int DEBLUR_FRAME_HYST     = 3;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SYNC,
    PH_R,
    PH_G,
    PH_B
  } phase_e;

endpackage

// File: rtl/n64adv_deblur_vote.sv
// Per-frame vote filter: the deblur decision only flips after
// FRAME_HYST consecutive frames vote against it.
module n64adv_deblur_vote
  import n64adv_deblur_detect_pkg::*;
#(
  parameter int FRAME_HYST = DEBLUR_FRAME_HYST
) (
  input  logic VCLK,
  input  logic nVRST,
  input  logic clr,
  input  logic vote_en,
  input  logic vote,
  output logic deblur_o
);

  localparam int HW = $clog2(FRAME_HYST + 1);

  logic [HW-1:0] hyst;

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      deblur_o <= 1'b0;
      hyst     <= '0;
    end else if (clr) begin
      deblur_o <= 1'b0;
      hyst     <= '0;
    end else if (vote_en) begin
      if (vote == deblur_o) begin
        hyst <= '0;
      end else if (hyst == HW'(FRAME_HYST - 1)) begin
        deblur_o <= vote;
        hyst     <= '0;
      end else begin
        hyst <= hyst + 1'b1;
      end
    end
  end

endmodule

// File: rtl/n64adv_deblur_detect.sv
// Watches the raw VD bus and recommends deblur when horizontal
// pixel pairs repeat, i.e. the content is 320 px wide.
module n64adv_deblur_detect
  import n64adv_deblur_detect_pkg::*;
#(
  parameter int color_width_i  = COLOR_W,
  parameter int DIFF_THRESHOLD = DEBLUR_DIFF_THRESHOLD,
  parameter int FRAME_HYST     = DEBLUR_FRAME_HYST,
  parameter int H_SKIP         = 8,
  parameter int CNT_W          = 16
) (
  input  logic                     VCLK,
  input  logic                     nVRST,
  input  logic                     nVDSYNC,
  input  logic [color_width_i-1:0] VD_i,
  input  logic                     n64_480i,
  input  logic                     enable,
  output logic                     deblur_o,
  output logic                     valid_o,
  output logic [CNT_W-1:0]         diff_cnt_o
);

  localparam int PX_W = 3 * color_width_i;

  phase_e phase_q, phase_d;

  logic [color_width_i-1:0] r_q, g_q;
  logic [PX_W-1:0]          prev_px, cur_px;
  logic                     vsync_q, hsync_q;
  logic [9:0]               px_cnt;
  logic [CNT_W-1:0]         cnt_even, cnt_odd;
  logic [CNT_W-1:0]         cnt_min;
  logic                     fe_q, first_q;
  logic                     vote_q, vote_en_q;
  logic                     is_sync, px_done;
  logic                     vs_fall, hs_rise;
  logic                     active, px_diff;
  logic                     force_clr;
  logic                     sync_unused;

  // a new sync word always restarts the pixel, even mid-pixel
  always_comb begin
    phase_d = PH_IDLE;
    if (!nVDSYNC) begin
      phase_d = PH_SYNC;
    end else begin
      unique case (phase_q)
        PH_SYNC: phase_d = PH_R;
        PH_R:    phase_d = PH_G;
        PH_G:    phase_d = PH_B;
        default: phase_d = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) phase_q <= PH_IDLE;
    else        phase_q <= phase_d;
  end

  assign is_sync   = (phase_d == PH_SYNC);
  assign px_done   = (phase_d == PH_B);
  assign cur_px    = {r_q, g_q, VD_i};
  assign vs_fall   = is_sync && !VD_i[VSYNC_BIT] && vsync_q;
  assign hs_rise   = is_sync && VD_i[HSYNC_BIT] && !hsync_q;
  assign active    = vsync_q && hsync_q
                  && (px_cnt >= 10'(H_SKIP));
  assign px_diff   = px_done && active && (cur_px != prev_px);
  assign force_clr = n64_480i || !enable;
  assign cnt_min   = (cnt_odd < cnt_even) ? cnt_odd : cnt_even;

  assign sync_unused = VD_i[CLAMP_BIT] ^ VD_i[CSYNC_BIT];

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      prev_px <= '0;
      px_cnt  <= '0;
    end else begin
      if (is_sync) begin
        vsync_q <= VD_i[VSYNC_BIT];
        hsync_q <= VD_i[HSYNC_BIT];
      end
      if (phase_d == PH_R) r_q <= VD_i;
      if (phase_d == PH_G) g_q <= VD_i;
      if (px_done) prev_px <= cur_px;
      if (hs_rise) begin
        px_cnt <= '0;
      end else if (px_done && px_cnt != '1) begin
        px_cnt <= px_cnt + 1'b1;
      end
    end
  end

  // both pair phases counted so alignment of the duplicates is irrelevant
  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      cnt_even <= '0;
      cnt_odd  <= '0;
    end else if (force_clr || fe_q) begin
      cnt_even <= '0;
      cnt_odd  <= '0;
    end else if (px_diff) begin
      if (px_cnt[0]) begin
        if (cnt_odd != '1) cnt_odd <= cnt_odd + 1'b1;
      end else begin
        if (cnt_even != '1) cnt_even <= cnt_even + 1'b1;
      end
    end
  end

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      fe_q       <= 1'b0;
      first_q    <= 1'b1;
      vote_q     <= 1'b0;
      vote_en_q  <= 1'b0;
      valid_o    <= 1'b0;
      diff_cnt_o <= '0;
    end else begin
      fe_q      <= vs_fall && !force_clr;
      vote_en_q <= 1'b0;
      if (force_clr) begin
        valid_o <= 1'b0;
        first_q <= 1'b1;
      end else if (fe_q) begin
        diff_cnt_o <= cnt_min;
        valid_o    <= 1'b1;
        vote_q     <= cnt_min < CNT_W'(DIFF_THRESHOLD);
        // the first frame after reset/clear was partial
        vote_en_q  <= !first_q;
        first_q    <= 1'b0;
      end
    end
  end

  n64adv_deblur_vote #(
    .FRAME_HYST(FRAME_HYST)
  ) u_vote (
    .VCLK    (VCLK),
    .nVRST   (nVRST),
    .clr     (force_clr),
    .vote_en (vote_en_q),
    .vote    (vote_q),
    .deblur_o(deblur_o)
  );

endmodule

// File: tb/tb_n64adv_deblur_detect.sv
// Directed bench for the auto-deblur detector with a frame scoreboard.
// Counters are narrowed to 8 bits so saturation is reachable quickly.
module tb_n64adv_deblur_detect;

  localparam int TB_CNT_W = 8;
  localparam int SAT      = (1 << TB_CNT_W) - 1;
  localparam int THR      = 16;
  localparam int HYST     = 3;
  localparam int NPX      = 40;
  localparam int SKIP     = 8;

  localparam int M_FLAT = 0;
  localparam int M_RAMP = 1;
  localparam int M_PAIR = 2;
  localparam int M_T15  = 3;
  localparam int M_T16  = 4;
  localparam int M_T17  = 5;
  localparam int M_RAND = 6;

  logic                VCLK = 1'b0;
  logic                nVRST;
  logic                nVDSYNC;
  logic [6:0]          VD_i;
  logic                n64_480i;
  logic                enable;
  logic                deblur_o;
  logic                valid_o;
  logic [TB_CNT_W-1:0] diff_cnt_o;

  typedef struct {
    int diff_b;
    int valid_b;
    int deblur_b;
    int diff_a;
    int deblur_a;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  int m_first  = 1;
  int m_valid  = 0;
  int m_deblur = 0;
  int m_hyst   = 0;
  int m_diff   = 0;

  n64adv_deblur_detect #(
    .CNT_W(TB_CNT_W)
  ) dut (
    .VCLK      (VCLK),
    .nVRST     (nVRST),
    .nVDSYNC   (nVDSYNC),
    .VD_i      (VD_i),
    .n64_480i  (n64_480i),
    .enable    (enable),
    .deblur_o  (deblur_o),
    .valid_o   (valid_o),
    .diff_cnt_o(diff_cnt_o)
  );

  always #5 VCLK = ~VCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] sw(input logic vs,
                                    input logic hs);
    return {3'b000, vs, 1'b1, hs, 1'b1};
  endfunction

  function automatic logic [20:0] gen(input int mode,
                                      input int l,
                                      input int k);
    case (mode)
      M_RAMP: return 21'(l * 64 + k);
      M_PAIR: return 21'(l * 64 + ((k + 1) >> 1));
      M_T15:  return (l == 0) ? 21'((k > 38) ? 38 : k) : 21'd0;
      M_T16:  return (l == 0) ? 21'(k) : 21'd0;
      M_T17:  return (l == 0) ? 21'(k)
                   : (l == 1 && k == 20) ? 21'd5 : 21'd0;
      M_RAND: return 21'($urandom_range(0, 21'h1FFFFF));
      default: return 21'd0;
    endcase
  endfunction

  task automatic cyc(input logic nvd, input logic [6:0] vd);
    nVDSYNC = nvd;
    VD_i    = vd;
    @(posedge VCLK);
    #1;
  endtask

  task automatic send_px(input logic vs, input logic hs,
                         input logic [20:0] v);
    cyc(1'b0, sw(vs, hs));
    cyc(1'b1, v[20:14]);
    cyc(1'b1, v[13:7]);
    cyc(1'b1, v[6:0]);
  endtask

  task automatic model_frame_end(input int e, input int o);
    exp_t x;
    int   es, os, ms, vote;
    es = (e > SAT) ? SAT : e;
    os = (o > SAT) ? SAT : o;
    ms = (es < os) ? es : os;
    x.diff_b   = m_diff;
    x.valid_b  = m_valid;
    x.deblur_b = m_deblur;
    m_diff  = ms;
    m_valid = 1;
    if (m_first != 0) begin
      m_first = 0;
    end else begin
      vote = (ms < THR) ? 1 : 0;
      if (vote == m_deblur) begin
        m_hyst = 0;
      end else begin
        m_hyst++;
        if (m_hyst == HYST) begin
          m_deblur = vote;
          m_hyst   = 0;
        end
      end
    end
    x.diff_a   = m_diff;
    x.deblur_a = m_deblur;
    sb.push_back(x);
  endtask

  task automatic model_clear();
    m_first  = 1;
    m_valid  = 0;
    m_deblur = 0;
    m_hyst   = 0;
  endtask

  // active lines of one frame; expectation queued at the end
  task automatic send_active(input int mode, input int nl,
                             input bit glitch, input int fline);
    int          e, o;
    logic [20:0] v, prev;
    e = 0;
    o = 0;
    prev = '0;
    for (int l = 0; l < nl; l++) begin
      for (int j = 0; j < 4; j++) begin
        if (l == fline && j == 0) begin
          n64_480i = 1'b1;
          cyc(1'b0, sw(1'b1, 1'b0));
          chk("force_deblur", 32'(deblur_o), 32'd0);
          chk("force_valid", 32'(valid_o), 32'd0);
          cyc(1'b1, 7'd0);
          cyc(1'b1, 7'd0);
          cyc(1'b1, 7'd0);
          n64_480i = 1'b0;
          model_clear();
          e = 0;
          o = 0;
        end else begin
          send_px(1'b1, 1'b0, 21'd0);
        end
        prev = '0;
      end
      for (int k = 0; k < NPX; k++) begin
        v = gen(mode, l, k);
        if (glitch && l == 0 && k == 20) begin
          cyc(1'b0, sw(1'b1, 1'b1));
          cyc(1'b1, 7'h55);
        end
        send_px(1'b1, 1'b1, v);
        if (k >= SKIP && v != prev) begin
          if (k % 2 == 1) o++;
          else            e++;
        end
        prev = v;
      end
    end
    model_frame_end(e, o);
  endtask

  // vsync line; its first sync word closes the previous frame
  task automatic send_vsync();
    exp_t x;
    chk("sb_pending", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    x = sb.pop_front();
    cyc(1'b0, sw(1'b0, 1'b0));
    chk("pre_diff", 32'(diff_cnt_o), x.diff_b);
    chk("pre_valid", 32'(valid_o), x.valid_b);
    chk("pre_deblur", 32'(deblur_o), x.deblur_b);
    cyc(1'b1, 7'd0);
    chk("fe_diff", 32'(diff_cnt_o), x.diff_a);
    chk("fe_valid", 32'(valid_o), 32'd1);
    chk("hold_deblur", 32'(deblur_o), x.deblur_b);
    cyc(1'b1, 7'd0);
    chk("deblur", 32'(deblur_o), x.deblur_a);
    cyc(1'b1, 7'd0);
    repeat (3) send_px(1'b0, 1'b0, 21'd0);
  endtask

  task automatic frame(input int mode, input int nl,
                       input bit glitch, input int fline);
    send_vsync();
    send_active(mode, nl, glitch, fline);
  endtask

  initial begin
    nVRST    = 1'b0;
    nVDSYNC  = 1'b1;
    VD_i     = '0;
    n64_480i = 1'b0;
    enable   = 1'b1;
    #12;
    chk("rst_deblur", 32'(deblur_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_diff", 32'(diff_cnt_o), 32'd0);
    #1 nVRST = 1'b1;
    @(posedge VCLK);
    #1;

    send_active(M_FLAT, 2, 1'b0, -1);
    repeat (4) frame(M_RAMP, 4, 1'b0, -1);
    repeat (3) frame(M_PAIR, 4, 1'b0, -1);

    repeat (2) frame(M_RAMP, 4, 1'b0, -1);
    frame(M_PAIR, 4, 1'b0, -1);
    repeat (3) frame(M_RAMP, 4, 1'b0, -1);

    repeat (3) frame(M_T15, 4, 1'b0, -1);
    frame(M_T17, 4, 1'b0, -1);
    frame(M_RAMP, 4, 1'b1, -1);
    frame(M_RAMP, 4, 1'b0, 1);
    repeat (3) frame(M_PAIR, 4, 1'b0, -1);
    repeat (3) frame(M_T16, 4, 1'b0, -1);
    frame(M_RAND, 20, 1'b0, -1);
    repeat (3) frame(M_PAIR, 4, 1'b0, -1);
    send_vsync();

    cyc(1'b0, sw(1'b1, 1'b1));
    cyc(1'b1, 7'h11);
    #2 nVRST = 1'b0;
    #1;
    chk("mid_rst_deblur", 32'(deblur_o), 32'd0);
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_diff", 32'(diff_cnt_o), 32'd0);
    repeat (2) @(posedge VCLK);
    #1;
    chk("hold_rst_deblur", 32'(deblur_o), 32'd0);
    nVRST = 1'b1;
    model_clear();
    m_diff = 0;

    send_active(M_PAIR, 2, 1'b0, -1);
    send_vsync();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
